// File: rtl/hasti_sram_slave.sv
// ----------------------------------------------------------------------------
// hasti_sram_slave
//
// AHB-Lite (HASTI) slave in front of a single-port 32-bit word memory.
// Supports byte, halfword and word transfers with little-endian byte lanes,
// a configurable number of data-phase wait states for OKAY transfers, and the
// two-cycle ERROR response for misaligned or oversized transfers.
//
// Parameters
//   WAIT_STATES  data-phase wait cycles per OKAY transfer (0..7)
//   DEPTH_WORDS  number of 32-bit memory words (power of two)
//
// Ports
//   hclk       in   clock, all state updates on the rising edge
//   hreset     in   synchronous active-high reset
//   hsel       in   slave select from the bus decoder
//   haddr      in   byte address, only the low log2(DEPTH_WORDS)+2 bits used
//   hwrite     in   1 = write, 0 = read
//   hsize      in   0 = byte, 1 = halfword, 2 = word
//   hburst     in   accepted, no effect
//   hprot      in   accepted, no effect
//   hmastlock  in   accepted, no effect
//   htrans     in   IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3
//   hready     in   bus-level ready, address phase sampled only when 1
//   hwdata     in   write data, valid in the data phase
//   hrdata     out  read data, zero outside read data phases
//   hreadyout  out  slave ready
//   hresp      out  0 = OKAY, 1 = ERROR
// ----------------------------------------------------------------------------
module hasti_sram_slave #(
    parameter int WAIT_STATES = 0,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hmastlock,
    input  logic [1:0]  htrans,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [2:0]    r_wait_cnt;
    logic [2:0]    w_next_wait_cnt;

    // Registered address phase
    logic [AW+1:0] r_addr;
    logic          r_write;
    logic [2:0]    r_size;

    logic          w_phase_done;
    logic          w_accept;
    logic          w_illegal;
    logic          w_commit;
    logic [3:0]    w_byte_en;
    logic [AW-1:0] w_word_idx;

    logic [31:0]   r_mem [DEPTH_WORDS];

    // Bus fields that carry no meaning for a plain memory slave.
    logic          w_unused;
    assign w_unused = ^{hburst, hprot, hmastlock, htrans[0], haddr[31:AW+2]};

    // The current data phase (if any) finishes this cycle. Only then may a new
    // address phase be taken; while low the registered address phase is held.
    assign w_phase_done = !((r_state == ST_ERR1) ||
                            (r_state == ST_DATA && r_wait_cnt != 3'd0));

    assign w_accept  = hsel && hready && htrans[1] && w_phase_done;

    assign w_illegal = (hsize > 3'd2) ||
                       (hsize == 3'd1 && haddr[0]) ||
                       (hsize == 3'd2 && haddr[1:0] != 2'b00);

    assign w_word_idx = r_addr[AW+1:2];

    // Write lands on the edge that ends the write data phase.
    assign w_commit = (r_state == ST_DATA) && (r_wait_cnt == 3'd0) && r_write;

    // ------------------------------------------------------------------------
    // Next-state and response decode
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case/if tree leaves a value unassigned and no latch forms.
        w_next_state    = ST_IDLE;
        w_next_wait_cnt = 3'd0;
        hreadyout       = w_phase_done;
        hresp           = (r_state == ST_ERR1) || (r_state == ST_ERR2);

        if (w_accept) begin
            if (w_illegal) begin
                w_next_state = ST_ERR1;
            end else begin
                w_next_state    = ST_DATA;
                w_next_wait_cnt = 3'(WAIT_STATES);
            end
        end else begin
            case (r_state)
                ST_DATA: begin
                    if (r_wait_cnt != 3'd0) begin
                        w_next_state    = ST_DATA;
                        w_next_wait_cnt = r_wait_cnt - 3'd1;
                    end
                end
                ST_ERR1: w_next_state = ST_ERR2;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Little-endian lane enables for the registered transfer. Illegal sizes
    // never reach ST_DATA, so the default only ever serves word transfers.
    always_comb begin
        case (r_size)
            3'd0:    w_byte_en = 4'b0001 << r_addr[1:0];
            3'd1:    w_byte_en = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_byte_en = 4'b1111;
        endcase
    end

    // ------------------------------------------------------------------------
    // State and address-phase registers
    // ------------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (hreset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 3'd0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_size     <= 3'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
            if (w_accept) begin
                r_addr  <= haddr[AW+1:0];
                r_write <= hwrite;
                r_size  <= hsize;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memory array
    // ------------------------------------------------------------------------
    // NOTE: the array has no reset branch on purpose; contents survive reset
    // and a reset on the commit edge simply drops the pending write.
    always_ff @(posedge hclk) begin
        if (w_commit && !hreset) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_word_idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // Full word during read data phases (wait cycles included), zero otherwise.
    assign hrdata = (r_state == ST_DATA && !r_write) ? r_mem[w_word_idx] : 32'h0;

endmodule
